// File: rtl/sort_sequencer.sv
// sort_sequencer: loads four unsigned words, sorts them ascending, then streams them out.
// Latency: SORT takes 6 cycles after the 4th accepted word; the first word is offered in the cycle after that.
// Backpressure: in_ready is low outside LOAD; DRAIN holds the current word and index while out_ready is low.
// Ports: clk/rst (async active-high); in_valid/in_ready/in_data load handshake;
//        cmp_a/cmp_b -> external comparator, cmp_max/cmp_min <- its same-cycle result;
//        out_valid/out_ready/out_data/out_last drain handshake; busy is high in SORT and DRAIN.
module sort_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] cmp_a,
   output logic [WIDTH-1:0] cmp_b,
   input  logic [WIDTH-1:0] cmp_max,
   input  logic [WIDTH-1:0] cmp_min,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SORT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       wcnt_q, wcnt_d;
   logic [1:0]       rcnt_q, rcnt_d;
   logic [2:0]       step_q, step_d;
   logic [WIDTH-1:0] slot_q [4];
   logic [WIDTH-1:0] slot_d [4];
   logic [1:0]       pair_lo;
   logic [1:0]       pair_hi;

   // Compare-exchange network for four elements: three passes that each shrink
   // by one, i.e. pairs (0,1),(1,2),(2,3),(0,1),(1,2),(0,1).
   always_comb begin
      case (step_q)
         3'd0, 3'd3, 3'd5: pair_lo = 2'd0;
         3'd1, 3'd4:       pair_lo = 2'd1;
         default:          pair_lo = 2'd2;
      endcase
      pair_hi = pair_lo + 2'd1;
   end

   // All outputs are pure decodes of the state registers, so reset clears them
   // immediately through the asynchronous flop reset.
   assign in_ready  = (state_q == ST_LOAD);
   assign busy      = (state_q != ST_LOAD);
   assign cmp_a     = (state_q == ST_SORT) ? slot_q[pair_lo] : '0;
   assign cmp_b     = (state_q == ST_SORT) ? slot_q[pair_hi] : '0;
   assign out_valid = (state_q == ST_DRAIN);
   assign out_data  = out_valid ? slot_q[rcnt_q] : '0;
   assign out_last  = out_valid && (rcnt_q == 2'd3);

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      rcnt_d  = rcnt_q;
      step_d  = step_q;
      for (int i = 0; i < 4; i++) begin
         slot_d[i] = slot_q[i];
      end

      case (state_q)
         ST_LOAD: begin
            if (in_valid) begin
               slot_d[wcnt_q] = in_data;
               wcnt_d         = wcnt_q + 2'd1;
               if (wcnt_q == 2'd3) begin
                  state_d = ST_SORT;
                  step_d  = 3'd0;
               end
            end
         end
         ST_SORT: begin
            // The min lands in the lower slot, so equal operands stay put.
            slot_d[pair_lo] = cmp_min;
            slot_d[pair_hi] = cmp_max;
            if (step_q == 3'd5) begin
               state_d = ST_DRAIN;
               rcnt_d  = 2'd0;
            end else begin
               step_d = step_q + 3'd1;
            end
         end
         ST_DRAIN: begin
            if (out_ready) begin
               rcnt_d = rcnt_q + 2'd1;
               if (rcnt_q == 2'd3) begin
                  state_d = ST_LOAD;
                  wcnt_d  = 2'd0;
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
            wcnt_d  = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_LOAD;
         wcnt_q  <= 2'd0;
         rcnt_q  <= 2'd0;
         step_q  <= 3'd0;
         for (int i = 0; i < 4; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
         step_q  <= step_d;
         for (int i = 0; i < 4; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

endmodule

// File: doc/sort_sequencer.md
SORT_SEQUENCER -- requirements
Module: sort_sequencer

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of every data word and of the comparator operands.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_ready  output  1  block accepts a word this cycle.
REQ-006 in_data  input  WIDTH  unsigned word to load.
REQ-007 cmp_a  output  WIDTH  first operand to the external max/min comparator.
REQ-008 cmp_b  output  WIDTH  second operand to the external comparator.
REQ-009 cmp_max  input  WIDTH  comparator result, larger of cmp_a and cmp_b (combinational, same cycle).
REQ-010 cmp_min  input  WIDTH  comparator result, smaller of cmp_a and cmp_b (combinational, same cycle).
REQ-011 out_valid  output  1  sorted word available.
REQ-012 out_ready  input  1  downstream accepts the word.
REQ-013 out_data  output  WIDTH  sorted word.
REQ-014 out_last  output  1  marks the 4th (largest) sorted word.
REQ-015 busy  output  1  high in SORT and DRAIN.

Function
REQ-016 The block SHALL hold four slot registers s0..s3 and implement states LOAD, SORT and DRAIN.
REQ-017 LOAD: in_ready=1; each cycle with in_valid&&in_ready SHALL write in_data to slot[wcnt] and increment the 2-bit counter wcnt; cycles without in_valid SHALL not advance.
REQ-018 The 4th accepted word (at edge E0) SHALL move the state to SORT with step=0.
REQ-019 SORT SHALL run exactly 6 steps, one per cycle, on pairs (0,1),(1,2),(2,3),(0,1),(1,2),(0,1) for step 0..5.
REQ-020 During step k on pair (i,i+1): cmp_a=slot[i], cmp_b=slot[i+1]; at the next edge slot[i]<=cmp_min and slot[i+1]<=cmp_max.
REQ-021 cmp_a and cmp_b SHALL be 0 in every state except SORT.
REQ-022 After the step-5 edge (E6), the state SHALL be DRAIN with rcnt=0; out_valid first high in the cycle following E6.
REQ-023 DRAIN: out_valid=1, out_data=slot[rcnt], out_last=(rcnt==3); each cycle with out_valid&&out_ready SHALL increment rcnt.
REQ-024 The handshake with rcnt==3 SHALL return the state to LOAD with wcnt=0; in_ready SHALL be high in the following cycle.
REQ-025 Result SHALL be ascending (s0 smallest); equal values SHALL be passed through unchanged.
REQ-026 in_ready SHALL be 0 in SORT and DRAIN; in_valid in those states SHALL be ignored.
REQ-027 While out_ready is low in DRAIN, out_data, out_last and rcnt SHALL hold, with no timeout.
REQ-028 out_ready while out_valid=0 SHALL have no effect; out_valid, out_data and out_last SHALL be 0 outside DRAIN.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for a clock edge, force state=LOAD, wcnt=rcnt=step=0, s0..s3=0, in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, cmp_a=cmp_b=0.
REQ-030 Reset asserted in any state, including mid-SORT or mid-DRAIN, SHALL discard the batch; the first edge after deassertion SHALL accept a new word if in_valid=1.

Verification
REQ-031 Load 8,12,13,10, out_ready=1 -> out_valid rises the cycle after E6; outputs 8,10,12,13 on consecutive cycles; out_last only with 13.
REQ-032 Load 15,14,13,12 (reverse) -> 12,13,14,15; load 1,2,3,4 (sorted) -> 1,2,3,4.
REQ-033 Load 5,5,0,5 -> 0,5,5,5; WIDTH=8 load 255,0,128,7 -> 0,7,128,255.
REQ-034 in_valid toggling 1,0,1,0,... during LOAD -> exactly 4 accepted words, SORT entered only after the 4th handshake.
REQ-035 out_ready low for 10 cycles at rcnt=1 -> out_data stays at the 2nd sorted value, busy=1, in_ready=0 throughout.
REQ-036 rst pulse during SORT step 3 -> all outputs 0 and in_ready=1 before the next edge; a new load of 9,3,6,1 yields 1,3,6,9.
